// File: rtl/lut_reg_pipe_pkg.sv
// ============================================================================
// Module   : lut_reg_pkg
// Brief    : Shared limits and elaboration helpers for the LUT register pipe.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lut_reg_pkg;

    localparam int MAX_IN     = 6;
    localparam int MAX_CH     = 16;
    localparam int MAX_DEPTH  = 8;
    localparam int OCC_PORT_W = 4;

    // Truth table with only the all-ones index set: an AND of every input.
    function automatic logic [(1 << MAX_IN)-1:0] lut_init_and(input int n);
        logic [(1 << MAX_IN)-1:0] tbl;
        tbl = '0;
        tbl[(1 << n) - 1] = 1'b1;
        return tbl;
    endfunction

    // Bits needed to count input reg + depth stages + output reg.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 3);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lut_reg_pipe_if.sv
// ============================================================================
// Module   : lut_reg_pipe_if
// Brief    : Data, config and status bundle of the LUT register pipe.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface lut_reg_pipe_if
    import lut_reg_pkg::*;
#(
    parameter int NUM_IN = 6,
    parameter int NUM_CH = 1
);

    logic                        ce;
    logic                        flush;
    logic                        in_valid;
    logic [NUM_CH*NUM_IN-1:0]    in_data;
    logic                        cfg_we;
    logic [(1 << NUM_IN)-1:0]    cfg_data;
    logic                        out_valid;
    logic [NUM_CH-1:0]           out_data;
    logic [OCC_PORT_W-1:0]       occupancy;

    modport master (
        output ce, flush, in_valid, in_data, cfg_we, cfg_data,
        input  out_valid, out_data, occupancy
    );

    modport slave (
        input  ce, flush, in_valid, in_data, cfg_we, cfg_data,
        output out_valid, out_data, occupancy
    );

endinterface

`default_nettype wire

// File: rtl/lut_reg_pipe_lut_cell.sv
// ============================================================================
// Module   : lut_cell
// Brief    : One combinational NUM_IN-input lookup table (index + table -> bit).
// Revision : 1.0
// ============================================================================
`default_nettype none

module lut_cell #(
    parameter int NUM_IN = 6
) (
    input  logic [NUM_IN-1:0]      idx_i,
    input  logic [(1 << NUM_IN)-1:0] tbl_i,
    output logic                   bit_o
);

    assign bit_o = tbl_i[idx_i];

endmodule

`default_nettype wire

// File: rtl/lut_reg_pipe.sv
// ============================================================================
// Module   : lut_reg_pipe
// Brief    : Input reg -> runtime LUT -> PIPE_DEPTH stages -> output reg,
//            with valid tracking, stall, flush and occupancy count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lut_reg_pipe
    import lut_reg_pkg::*;
#(
    parameter int NUM_IN     = 6,
    parameter int NUM_CH     = 1,
    parameter int PIPE_DEPTH = 2,
    parameter logic [(1 << NUM_IN)-1:0] LUT_INIT = (1 << NUM_IN)'(lut_init_and(NUM_IN))
) (
    input  logic          clock0,
    input  logic          reset,
    lut_reg_pipe_if.slave bus
);

    localparam int c_tbl_w  = 1 << NUM_IN;
    localparam int c_data_w = NUM_CH * NUM_IN;
    localparam int c_nv     = PIPE_DEPTH + 2;
    localparam int c_occ_w  = occ_width(PIPE_DEPTH);

    logic [c_tbl_w-1:0]  r_tbl_q;
    logic [c_data_w-1:0] r_in_q;
    logic [NUM_CH-1:0]   r_out_q;
    logic [NUM_CH-1:0]   w_lut;
    logic [NUM_CH-1:0]   w_tail;
    logic [c_nv-1:0]     r_vld_q;
    logic [c_nv-1:0]     w_vld_d;
    logic [c_occ_w-1:0]  r_occ_q;
    logic [c_occ_w-1:0]  w_occ_d;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_cell
        lut_cell #(
            .NUM_IN (NUM_IN)
        ) u_cell (
            .idx_i (r_in_q[c*NUM_IN +: NUM_IN]),
            .tbl_i (r_tbl_q),
            .bit_o (w_lut[c])
        );
    end

    if (PIPE_DEPTH == 0) begin : g_nopipe
        assign w_tail = w_lut;
    end else begin : g_pipe
        logic [PIPE_DEPTH-1:0][NUM_CH-1:0] r_stg_q;

        always_ff @(posedge clock0 or posedge reset) begin
            if (reset) begin
                r_stg_q <= '0;
            end else if (bus.ce) begin
                r_stg_q[0] <= w_lut;
                for (int k = 1; k < PIPE_DEPTH; k++) begin
                    r_stg_q[k] <= r_stg_q[k-1];
                end
            end
        end

        assign w_tail = r_stg_q[PIPE_DEPTH-1];
    end

    // Valid bits form one shift vector: bit 0 = input reg, MSB = output reg.
    always_comb begin
        w_vld_d = r_vld_q;
        if (bus.flush) begin
            w_vld_d = '0;
        end else if (bus.ce) begin
            w_vld_d = {r_vld_q[c_nv-2:0], bus.in_valid};
        end
    end

    always_comb begin
        w_occ_d = '0;
        for (int i = 0; i < c_nv; i++) begin
            w_occ_d = w_occ_d + c_occ_w'(w_vld_d[i]);
        end
    end

    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) begin
            r_tbl_q <= LUT_INIT;
            r_in_q  <= '0;
            r_out_q <= '0;
            r_vld_q <= '0;
            r_occ_q <= '0;
        end else begin
            r_vld_q <= w_vld_d;
            r_occ_q <= w_occ_d;
            // Table writes ignore stall and flush; results already past the LUT keep the old table.
            if (bus.cfg_we) begin
                r_tbl_q <= bus.cfg_data;
            end
            if (bus.ce) begin
                r_in_q  <= bus.in_data;
                r_out_q <= w_tail;
            end
        end
    end

    assign bus.out_valid = r_vld_q[c_nv-1];
    assign bus.out_data  = r_out_q;
    assign bus.occupancy = OCC_PORT_W'(r_occ_q);

endmodule

`default_nettype wire
